// File: rtl/axi_stream_packet_gen.sv
// AXI4-Stream packet source: one packet per start with an incrementing data pattern from seed, and a partial keep mask on the last beat.
// Latency start->first tvalid 1 cycle; beats hold while m_tready is low; all outputs registered.
module axi_stream_packet_gen #(
  parameter int LEN_WIDTH  = 16,
  parameter int IPG_CYCLES = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [31:0]          seed,
  input  logic                 cfg_tid,
  input  logic                 cfg_tdest,
  output logic [31:0]          m_tdata,
  output logic [3:0]           m_tkeep,
  output logic [3:0]           m_tstrb,
  output logic                 m_tlast,
  output logic                 m_tuser,
  output logic                 m_tid,
  output logic                 m_tdest,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [LEN_WIDTH-2:0] BEAT_ONE  = 1;
  localparam logic [LEN_WIDTH-2:0] BEAT_ZERO = 0;

  logic [1:0]           state;
  logic [LEN_WIDTH-2:0] beats_left;   // beats still to follow the one on the bus
  logic [1:0]           last_sel;     // (pkt_len-1) mod 4, selects final keep mask
  logic [GW-1:0]        gap_cnt;
  logic [LEN_WIDTH-1:0] len_m1;
  logic [LEN_WIDTH-2:0] beats_init;

  assign len_m1     = pkt_len - LEN_WIDTH'(1);
  assign beats_init = {1'b0, len_m1[LEN_WIDTH-1:2]};
  assign m_tstrb    = m_tkeep;

  function automatic logic [3:0] last_keep(input logic [1:0] sel);
    case (sel)
      2'd0:    last_keep = 4'b0001;
      2'd1:    last_keep = 4'b0011;
      2'd2:    last_keep = 4'b0111;
      default: last_keep = 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beats_left <= '0;
      last_sel   <= '0;
      gap_cnt    <= '0;
      m_tdata    <= '0;
      m_tkeep    <= '0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
      m_tid      <= 1'b0;
      m_tdest    <= 1'b0;
      m_tvalid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pkt_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (pkt_len != '0)) begin
            state      <= SEND;
            busy       <= 1'b1;
            beats_left <= beats_init;
            last_sel   <= len_m1[1:0];
            m_tvalid   <= 1'b1;
            m_tdata    <= seed;
            m_tuser    <= 1'b1;
            m_tid      <= cfg_tid;
            m_tdest    <= cfg_tdest;
            m_tlast    <= (beats_init == BEAT_ZERO);
            m_tkeep    <= (beats_init == BEAT_ZERO) ? last_keep(len_m1[1:0]) : 4'b1111;
          end
        end
        SEND: begin
          if (m_tvalid && m_tready) begin
            if (m_tlast) begin
              m_tvalid  <= 1'b0;
              m_tlast   <= 1'b0;
              m_tuser   <= 1'b0;
              m_tkeep   <= 4'b0000;
              done      <= 1'b1;
              pkt_count <= pkt_count + CNT_WIDTH'(1);
              if (IPG_CYCLES > 0) begin
                state   <= GAP;
                gap_cnt <= GW'(IPG_CYCLES - 1);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              m_tdata    <= m_tdata + 32'd1;
              m_tuser    <= 1'b0;
              beats_left <= beats_left - BEAT_ONE;
              m_tlast    <= (beats_left == BEAT_ONE);
              m_tkeep    <= (beats_left == BEAT_ONE) ? last_keep(last_sel) : 4'b1111;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          m_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_stream_packet_gen.md
Name: axi_stream_packet_gen

Overview:
AXI4-Stream transmitter (master side) that builds one packet per start request: byte-length-driven beat count, incrementing data pattern from a seed, partial tkeep/tstrb on the final beat, tlast. Drives the s_* side of the existing stream pass-through, or any AXI-Stream sink, and serves as the traffic source for stream-path bring-up and test.

Parameters:
LEN_WIDTH, 16, width of byte-length input; max packet 2^LEN_WIDTH-1 bytes
IPG_CYCLES, 2, idle cycles forced after each packet's final handshake (0 allowed)
CNT_WIDTH, 16, width of sent-packet counter

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request one packet; sampled only in IDLE
pkt_len  input  LEN_WIDTH  packet length in bytes; sampled with start
seed  input  32  data value of first beat; sampled with start
cfg_tid  input  1  tid for packet; sampled with start
cfg_tdest  input  1  tdest for packet; sampled with start
m_tdata  output  32  beat data
m_tkeep  output  4  byte-valid mask
m_tstrb  output  4  equals m_tkeep
m_tlast  output  1  final beat marker
m_tuser  output  1  high on first beat only (start-of-frame)
m_tid  output  1  latched cfg_tid
m_tdest  output  1  latched cfg_tdest
m_tvalid  output  1  beat valid
m_tready  input  1  sink ready
busy  output  1  high in SEND or GAP
done  output  1  one-cycle pulse after final beat handshake
pkt_count  output  CNT_WIDTH  packets fully sent, wraps at 2^CNT_WIDTH

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, incl. m_tvalid, busy, done, pkt_count.
- All outputs registered; no combinational path m_tready -> any output.
- FSM IDLE/SEND/GAP.
- IDLE: start=1 and pkt_len!=0 -> latch pkt_len, seed, cfg_tid, cfg_tdest; beats = ceil(pkt_len/4); next cycle SEND with m_tvalid=1, m_tdata=seed, m_tuser=1. Latency start -> first m_tvalid = 1 cycle. start with pkt_len=0: ignored, stays IDLE, no done.
- start ignored while busy=1 (not queued).
- SEND: handshake = m_tvalid & m_tready. Without handshake, every m_* output holds stable; m_tvalid never deasserts mid-packet. On handshake of beat k (0-based), beat k+1 presented the next cycle: m_tdata = seed+k+1 (mod 2^32), m_tuser=0. Back-to-back beats at full rate when m_tready stays high.
- Final beat (k = beats-1): m_tlast=1; m_tkeep by pkt_len mod 4: 0->1111, 1->0001, 2->0011, 3->0111. Non-final beats m_tkeep=1111. Single-beat packet: m_tuser=1 and m_tlast=1 together.
- Final handshake: next cycle m_tvalid=0, m_tlast=0, done=1 for one cycle, pkt_count+1; state GAP if IPG_CYCLES>0 else IDLE.
- GAP: busy=1, m_tvalid=0 for exactly IPG_CYCLES cycles, then IDLE. Minimum spacing final handshake -> next first beat = IPG_CYCLES+2 cycles.
- pkt_len = 2^LEN_WIDTH-1 handled without overflow in beat counter (counter width LEN_WIDTH-1).
- rst_n asserted mid-packet: m_tvalid drops immediately, packet abandoned, no done, pkt_count cleared.

Test Plan:
- pkt_len=8, seed=0x1000_0000, m_tready=1, start pulse -> 2 beats on consecutive cycles: 0x1000_0000 (tuser=1, tkeep=F), 0x1000_0001 (tlast=1, tkeep=F); done one cycle later; pkt_count=1.
- pkt_len=7, seed=0xFFFF_FFFF -> beats 0xFFFF_FFFF then 0x0000_0000 with tlast=1, tkeep=tstrb=0111 (wrap check).
- pkt_len=1 -> single beat with tuser=1, tlast=1, tkeep=0001; pkt_len=0 start -> no m_tvalid, no done, busy stays 0.
- pkt_len=16, m_tready pseudo-random 50% -> 4 beats exact, all outputs stable on every stalled cycle, m_tvalid never drops before tlast handshake.
- start held high continuously, IPG_CYCLES=2, pkt_len=4 -> m_tvalid pulses separated by 3 low cycles; start during SEND/GAP ignored; pkt_count increments per packet.
- rst_n low on beat 2 of 4-beat packet -> m_tvalid=0 same cycle (async); after release IDLE, pkt_count=0, new start produces a clean packet from beat 0.
